mdata_stripper: RTL and testbench
=================================

Name: mdata_stripper

Overview:
- Receive-side counterpart of the metadata insertion path.
- Accepts one AXI-Stream carrying packets whose first beat is a metadata word, strips that beat onto a dedicated metadata stream, and routes the remaining payload beats to one of two output streams selected by a field in the metadata.
- Sits between the ingress stream and the two per-channel payload consumers.

Parameters:
- DW, 128, data width of every stream in bits; tkeep width DW/8.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- md_enable  input  1  1 = first beat of each packet is metadata; 0 = pass-through mode.
- axis_in_tdata  input  DW  ingress data.
- axis_in_tkeep  input  DW/8  ingress byte enables.
- axis_in_tlast  input  1  ingress end of packet.
- axis_in_tvalid  input  1  ingress valid.
- axis_in_tready  output  1  ingress ready.
- axis_out_md_tdata  output  DW  stripped metadata word.
- axis_out_md_tvalid  output  1  metadata valid.
- axis_out_md_tready  input  1  metadata ready.
- axis_out1_tdata/tkeep/tlast/tvalid  output  DW, DW/8, 1, 1  payload channel 1.
- axis_out1_tready  input  1  channel 1 ready.
- axis_out2_tdata/tkeep/tlast/tvalid  output  DW, DW/8, 1, 1  payload channel 2.
- axis_out2_tready  input  1  channel 2 ready.
- pkt_count  output  16  packets fully accepted (tlast beat accepted); wraps 0xFFFF -> 0.
- hdr_only_err  output  1  sticky; set when a metadata beat arrives with tlast=1.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values:
  - All tvalid = 0; all tdata/tkeep/tlast = 0.
  - pkt_count = 0, hdr_only_err = 0, axis_in_tready = 0 while reset is asserted.
  - State = S_HDR, sel = 0.
- Output buffering: each of the three outputs is a one-entry register slot.
  - A slot is free when tvalid = 0 or its tready = 1.
  - Latency is one cycle from input handshake to output tvalid.
  - Outputs hold stable while tvalid=1 and tready=0.
- FSM, state S_HDR (expecting the first beat of a packet):
  - md_enable is sampled only on the accepted first beat; changes mid-packet are ignored until the next S_HDR.
  - md_enable=1: axis_in_tready = md slot free.
    - On accept: beat goes to the md slot; sel <= tdata[0] (0 -> out1, 1 -> out2).
    - tlast=0: go to S_BODY.
    - tlast=1: stay in S_HDR, set hdr_only_err, increment pkt_count, emit no payload.
  - md_enable=0: the beat is payload to out1 (sel <= 0); axis_in_tready = out1 slot free.
    - tlast=0: go to S_BODY.
    - tlast=1: stay in S_HDR, increment pkt_count.
- FSM, state S_BODY:
  - axis_in_tready = slot[sel] free.
  - Each accepted beat is copied (tdata, tkeep, tlast) to out[sel].
  - On an accepted tlast beat: increment pkt_count, go to S_HDR.
- Back-to-back: a new header may be accepted in the cycle after the prior tlast beat. Full throughput is one beat/cycle when sinks are ready.
- Simultaneous load/drain: in the same cycle a slot drains (tready=1) and reloads, the slot keeps tvalid=1 with the new beat.
- Metadata is not held back waiting for payload. md and payload slots are independent; md may drain before or after payload.
- Reset mid-packet: all slots are cleared and any partial packet is dropped. After reset, the next beat is treated as a header.
- hdr_only_err is cleared only by reset.

Test Plan:
- md_enable=1, one packet: beats {0x...0000, A1, A2(tlast)}, all readies high -> md_tdata=0x...0000 one cycle after accept; out1 emits A1, A2 with A2 tlast=1; out2 idle; pkt_count=1.
- md_enable=1, header tdata[0]=1, three payload beats, out2_tready low for 4 cycles -> axis_in_tready=0 while out2 slot full; out2 data stable; after release all 3 beats are delivered in order; nothing on out1.
- md_enable=0, two 2-beat packets back-to-back -> all 4 beats on out1 with tkeep preserved; no md_tvalid; pkt_count=2; throughput 1 beat/cycle.
- Header with tlast=1 -> md beat emitted, hdr_only_err=1, pkt_count+1, next beat treated as a header.
- Toggle md_enable 1->0 during S_BODY, then reset asserted mid-packet -> current packet still routed per its header until reset; on reset all tvalid=0, pkt_count=0; the following beat is parsed as a header.
- Preload pkt_count near wrap by sending 65536 single-beat packets (md_enable=0) -> pkt_count returns to 0.

Source files
------------

// File: rtl/mdata_stripper.sv
// Receive-side metadata stripper: peels the leading metadata beat off each
// ingress packet and steers the payload to channel 1 or 2 by metadata bit 0.
module mdata_stripper #(
    parameter int DW = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              md_enable,
    input  logic [DW-1:0]     axis_in_tdata,
    input  logic [DW/8-1:0]   axis_in_tkeep,
    input  logic              axis_in_tlast,
    input  logic              axis_in_tvalid,
    output logic              axis_in_tready,
    output logic [DW-1:0]     axis_out_md_tdata,
    output logic              axis_out_md_tvalid,
    input  logic              axis_out_md_tready,
    output logic [DW-1:0]     axis_out1_tdata,
    output logic [DW/8-1:0]   axis_out1_tkeep,
    output logic              axis_out1_tlast,
    output logic              axis_out1_tvalid,
    input  logic              axis_out1_tready,
    output logic [DW-1:0]     axis_out2_tdata,
    output logic [DW/8-1:0]   axis_out2_tkeep,
    output logic              axis_out2_tlast,
    output logic              axis_out2_tvalid,
    input  logic              axis_out2_tready,
    output logic [15:0]       pkt_count,
    output logic              hdr_only_err
);

    localparam int KW = DW / 8;

    typedef enum logic {
        S_HDR  = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t        state_q;
    logic          sel_q;
    logic [15:0]   pkt_count_q;
    logic          hdr_only_err_q;

    logic [DW-1:0] md_tdata_q, md_tdata_d;
    logic          md_tvalid_q, md_tvalid_d;

    logic [DW-1:0] o1_tdata_q, o1_tdata_d;
    logic [KW-1:0] o1_tkeep_q, o1_tkeep_d;
    logic          o1_tlast_q, o1_tlast_d;
    logic          o1_tvalid_q, o1_tvalid_d;

    logic [DW-1:0] o2_tdata_q, o2_tdata_d;
    logic [KW-1:0] o2_tkeep_q, o2_tkeep_d;
    logic          o2_tlast_q, o2_tlast_d;
    logic          o2_tvalid_q, o2_tvalid_d;

    logic md_free, o1_free, o2_free;
    logic in_ready, accept;
    logic load_md, load_o1, load_o2;

    // A slot can take a new beat when empty or when it drains this same cycle.
    always_comb begin
        md_free  = !md_tvalid_q || axis_out_md_tready;
        o1_free  = !o1_tvalid_q || axis_out1_tready;
        o2_free  = !o2_tvalid_q || axis_out2_tready;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        in_ready = 1'b0;
        case (state_q)
            S_HDR:   in_ready = md_enable ? md_free : o1_free;
            S_BODY:  in_ready = sel_q ? o2_free : o1_free;
            default: in_ready = 1'b0;
        endcase
    end

    assign axis_in_tready = in_ready && !reset;
    assign accept         = axis_in_tvalid && axis_in_tready;

    assign load_md = accept && (state_q == S_HDR) && md_enable;
    assign load_o1 = accept && (((state_q == S_HDR) && !md_enable) ||
                                ((state_q == S_BODY) && !sel_q));
    assign load_o2 = accept && (state_q == S_BODY) && sel_q;

    always_comb begin
        md_tvalid_d = md_tvalid_q;
        md_tdata_d  = md_tdata_q;
        if (load_md) begin
            md_tvalid_d = 1'b1;
            md_tdata_d  = axis_in_tdata;
        end else if (axis_out_md_tready) begin
            md_tvalid_d = 1'b0;
        end

        o1_tvalid_d = o1_tvalid_q;
        o1_tdata_d  = o1_tdata_q;
        o1_tkeep_d  = o1_tkeep_q;
        o1_tlast_d  = o1_tlast_q;
        if (load_o1) begin
            o1_tvalid_d = 1'b1;
            o1_tdata_d  = axis_in_tdata;
            o1_tkeep_d  = axis_in_tkeep;
            o1_tlast_d  = axis_in_tlast;
        end else if (axis_out1_tready) begin
            o1_tvalid_d = 1'b0;
        end

        o2_tvalid_d = o2_tvalid_q;
        o2_tdata_d  = o2_tdata_q;
        o2_tkeep_d  = o2_tkeep_q;
        o2_tlast_d  = o2_tlast_q;
        if (load_o2) begin
            o2_tvalid_d = 1'b1;
            o2_tdata_d  = axis_in_tdata;
            o2_tkeep_d  = axis_in_tkeep;
            o2_tlast_d  = axis_in_tlast;
        end else if (axis_out2_tready) begin
            o2_tvalid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_tvalid_q <= 1'b0;
            md_tdata_q  <= '0;
            o1_tvalid_q <= 1'b0;
            o1_tdata_q  <= '0;
            o1_tkeep_q  <= '0;
            o1_tlast_q  <= 1'b0;
            o2_tvalid_q <= 1'b0;
            o2_tdata_q  <= '0;
            o2_tkeep_q  <= '0;
            o2_tlast_q  <= 1'b0;
        end else begin
            md_tvalid_q <= md_tvalid_d;
            md_tdata_q  <= md_tdata_d;
            o1_tvalid_q <= o1_tvalid_d;
            o1_tdata_q  <= o1_tdata_d;
            o1_tkeep_q  <= o1_tkeep_d;
            o1_tlast_q  <= o1_tlast_d;
            o2_tvalid_q <= o2_tvalid_d;
            o2_tdata_q  <= o2_tdata_d;
            o2_tkeep_q  <= o2_tkeep_d;
            o2_tlast_q  <= o2_tlast_d;
        end
    end

    // Packet framing: md_enable and the route are latched only on a header beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_HDR;
            sel_q          <= 1'b0;
            pkt_count_q    <= 16'd0;
            hdr_only_err_q <= 1'b0;
        end else if (accept) begin
            if (axis_in_tlast) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            case (state_q)
                S_HDR: begin
                    sel_q <= md_enable && axis_in_tdata[0];
                    if (md_enable && axis_in_tlast) begin
                        hdr_only_err_q <= 1'b1;
                    end
                    state_q <= axis_in_tlast ? S_HDR : S_BODY;
                end
                S_BODY: begin
                    if (axis_in_tlast) begin
                        state_q <= S_HDR;
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign axis_out_md_tdata  = md_tdata_q;
    assign axis_out_md_tvalid = md_tvalid_q;

    assign axis_out1_tdata    = o1_tdata_q;
    assign axis_out1_tkeep    = o1_tkeep_q;
    assign axis_out1_tlast    = o1_tlast_q;
    assign axis_out1_tvalid   = o1_tvalid_q;

    assign axis_out2_tdata    = o2_tdata_q;
    assign axis_out2_tkeep    = o2_tkeep_q;
    assign axis_out2_tlast    = o2_tlast_q;
    assign axis_out2_tvalid   = o2_tvalid_q;

    assign pkt_count          = pkt_count_q;
    assign hdr_only_err       = hdr_only_err_q;

endmodule

// File: tb/tb_mdata_stripper.sv
// Bench for mdata_stripper: directed scenarios plus random traffic, all
// outputs scored every cycle against a packet-level reference model.
module tb_mdata_stripper;

    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef logic [DW-1:0] data_t;
    typedef logic [KW-1:0] keep_t;

    typedef struct {
        data_t data;
        keep_t keep;
        logic  last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_enable;
    data_t       axis_in_tdata;
    keep_t       axis_in_tkeep;
    logic        axis_in_tlast;
    logic        axis_in_tvalid;
    logic        axis_in_tready;
    data_t       axis_out_md_tdata;
    logic        axis_out_md_tvalid;
    logic        axis_out_md_tready;
    data_t       axis_out1_tdata;
    keep_t       axis_out1_tkeep;
    logic        axis_out1_tlast;
    logic        axis_out1_tvalid;
    logic        axis_out1_tready;
    data_t       axis_out2_tdata;
    keep_t       axis_out2_tkeep;
    logic        axis_out2_tlast;
    logic        axis_out2_tvalid;
    logic        axis_out2_tready;
    logic [15:0] pkt_count;
    logic        hdr_only_err;

    mdata_stripper #(.DW(DW)) dut (
        .clk                (clk),
        .reset              (reset),
        .md_enable          (md_enable),
        .axis_in_tdata      (axis_in_tdata),
        .axis_in_tkeep      (axis_in_tkeep),
        .axis_in_tlast      (axis_in_tlast),
        .axis_in_tvalid     (axis_in_tvalid),
        .axis_in_tready     (axis_in_tready),
        .axis_out_md_tdata  (axis_out_md_tdata),
        .axis_out_md_tvalid (axis_out_md_tvalid),
        .axis_out_md_tready (axis_out_md_tready),
        .axis_out1_tdata    (axis_out1_tdata),
        .axis_out1_tkeep    (axis_out1_tkeep),
        .axis_out1_tlast    (axis_out1_tlast),
        .axis_out1_tvalid   (axis_out1_tvalid),
        .axis_out1_tready   (axis_out1_tready),
        .axis_out2_tdata    (axis_out2_tdata),
        .axis_out2_tkeep    (axis_out2_tkeep),
        .axis_out2_tlast    (axis_out2_tlast),
        .axis_out2_tvalid   (axis_out2_tvalid),
        .axis_out2_tready   (axis_out2_tready),
        .pkt_count          (pkt_count),
        .hdr_only_err       (hdr_only_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rand_ready = 1'b0;

    // Reference model: expected contents of each output, plus packet framing.
    data_t       exp_md[$];
    beat_t       exp_o1[$];
    beat_t       exp_o2[$];
    bit          m_in_pkt = 1'b0;
    bit          m_sel    = 1'b0;
    logic [15:0] m_cnt    = 16'd0;
    bit          m_err    = 1'b0;

    function automatic data_t rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sinks: drive readies just after each edge, randomly when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) begin
            axis_out_md_tready = ($urandom_range(0, 3) != 0);
            axis_out1_tready   = ($urandom_range(0, 3) != 0);
            axis_out2_tready   = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard: sampled on the falling edge, midway between active edges.
    initial forever begin
        int    n_md, n1, n2;
        bit    exp_ready;
        beat_t b;
        @(negedge clk);
        if (reset) begin
            exp_md.delete();
            exp_o1.delete();
            exp_o2.delete();
            m_in_pkt = 1'b0;
            m_sel    = 1'b0;
            m_cnt    = 16'd0;
            m_err    = 1'b0;
        end else begin
            n_md = exp_md.size();
            n1   = exp_o1.size();
            n2   = exp_o2.size();

            checks++;
            if (axis_out_md_tvalid !== (n_md != 0)) begin
                failures++;
                $display("FAIL md_valid: got %b want %b at cyc %0d", axis_out_md_tvalid, n_md != 0, cyc);
            end
            if (axis_out_md_tvalid === 1'b1 && n_md != 0) begin
                checks++;
                if (axis_out_md_tdata !== exp_md[0]) begin
                    failures++;
                    $display("FAIL md_data: got %h want %h", axis_out_md_tdata, exp_md[0]);
                end
                if (axis_out_md_tready) void'(exp_md.pop_front());
            end

            checks++;
            if (axis_out1_tvalid !== (n1 != 0)) begin
                failures++;
                $display("FAIL out1_valid: got %b want %b at cyc %0d", axis_out1_tvalid, n1 != 0, cyc);
            end
            if (axis_out1_tvalid === 1'b1 && n1 != 0) begin
                checks++;
                if (axis_out1_tdata !== exp_o1[0].data || axis_out1_tkeep !== exp_o1[0].keep ||
                    axis_out1_tlast !== exp_o1[0].last) begin
                    failures++;
                    $display("FAIL out1_beat: got %h/%h/%b want %h/%h/%b", axis_out1_tdata, axis_out1_tkeep,
                             axis_out1_tlast, exp_o1[0].data, exp_o1[0].keep, exp_o1[0].last);
                end
                if (axis_out1_tready) void'(exp_o1.pop_front());
            end

            checks++;
            if (axis_out2_tvalid !== (n2 != 0)) begin
                failures++;
                $display("FAIL out2_valid: got %b want %b at cyc %0d", axis_out2_tvalid, n2 != 0, cyc);
            end
            if (axis_out2_tvalid === 1'b1 && n2 != 0) begin
                checks++;
                if (axis_out2_tdata !== exp_o2[0].data || axis_out2_tkeep !== exp_o2[0].keep ||
                    axis_out2_tlast !== exp_o2[0].last) begin
                    failures++;
                    $display("FAIL out2_beat: got %h/%h/%b want %h/%h/%b", axis_out2_tdata, axis_out2_tkeep,
                             axis_out2_tlast, exp_o2[0].data, exp_o2[0].keep, exp_o2[0].last);
                end
                if (axis_out2_tready) void'(exp_o2.pop_front());
            end

            // The target output may take a beat if it holds nothing or is draining now.
            if (!m_in_pkt)
                exp_ready = md_enable ? (n_md == 0 || axis_out_md_tready) : (n1 == 0 || axis_out1_tready);
            else
                exp_ready = m_sel ? (n2 == 0 || axis_out2_tready) : (n1 == 0 || axis_out1_tready);
            checks++;
            if (axis_in_tready !== exp_ready) begin
                failures++;
                $display("FAIL in_ready: got %b want %b at cyc %0d", axis_in_tready, exp_ready, cyc);
            end

            checks++;
            if (pkt_count !== m_cnt || hdr_only_err !== m_err) begin
                failures++;
                $display("FAIL counters: got cnt=%0d err=%b want cnt=%0d err=%b", pkt_count, hdr_only_err, m_cnt, m_err);
            end

            if (axis_in_tvalid && axis_in_tready) begin
                b = '{axis_in_tdata, axis_in_tkeep, axis_in_tlast};
                if (!m_in_pkt) begin
                    if (md_enable) begin
                        exp_md.push_back(axis_in_tdata);
                        m_sel = axis_in_tdata[0];
                        if (axis_in_tlast) m_err = 1'b1;
                    end else begin
                        m_sel = 1'b0;
                        exp_o1.push_back(b);
                    end
                    if (!axis_in_tlast) m_in_pkt = 1'b1;
                end else begin
                    if (m_sel) exp_o2.push_back(b);
                    else       exp_o1.push_back(b);
                    if (axis_in_tlast) m_in_pkt = 1'b0;
                end
                if (axis_in_tlast) m_cnt = m_cnt + 16'd1;
            end
        end
    end

    task automatic drive_beat(input data_t d, input keep_t k, input logic l);
        int waited = 0;
        axis_in_tdata  = d;
        axis_in_tkeep  = k;
        axis_in_tlast  = l;
        axis_in_tvalid = 1'b1;
        @(negedge clk);
        while (axis_in_tready !== 1'b1 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (axis_in_tready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", axis_in_tready, waited);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        axis_in_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic all_ready();
        rand_ready         = 1'b0;
        axis_out_md_tready = 1'b1;
        axis_out1_tready   = 1'b1;
        axis_out2_tready   = 1'b1;
    endtask

    task automatic do_reset();
        axis_in_tvalid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Header (when md_en) carries the route in bit 0; body beats toggle md_enable freely.
    task automatic send_pkt(input bit md_en, input bit sel, input int n_payload, input bit gaps);
        data_t hdr;
        md_enable = md_en;
        if (md_en) begin
            hdr    = rnd_data();
            hdr[0] = sel;
            drive_beat(hdr, keep_t'($urandom()), n_payload == 0);
        end
        for (int i = 0; i < n_payload; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            if (md_en || i > 0) md_enable = 1'($urandom());
            drive_beat(rnd_data(), keep_t'($urandom()), i == n_payload - 1);
        end
        axis_in_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        md_enable      = 1'b1;
        axis_in_tdata  = rnd_data();
        axis_in_tkeep  = '1;
        axis_in_tlast  = 1'b0;
        axis_in_tvalid = 1'b1;
        all_ready();
        repeat (3) @(negedge clk);
        checks++;
        if (axis_in_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 0", axis_in_tready);
        end
        checks++;
        if ({axis_out_md_tvalid, axis_out1_tvalid, axis_out2_tvalid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valids: got %b want 000", {axis_out_md_tvalid, axis_out1_tvalid, axis_out2_tvalid});
        end
        checks++;
        if (axis_out_md_tdata !== '0 || axis_out1_tdata !== '0 || axis_out2_tdata !== '0 ||
            axis_out1_tkeep !== '0 || axis_out2_tkeep !== '0 || axis_out1_tlast !== 1'b0 ||
            axis_out2_tlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: got md=%h o1=%h o2=%h want all zero", axis_out_md_tdata, axis_out1_tdata, axis_out2_tdata);
        end
        checks++;
        if (pkt_count !== 16'd0 || hdr_only_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_counters: got cnt=%0d err=%b want 0/0", pkt_count, hdr_only_err);
        end
        do_reset();
    endtask

    task automatic test_single_md();
        data_t zero_hdr = '0;
        all_ready();
        md_enable = 1'b1;
        drive_beat(zero_hdr, '1, 1'b0);
        checks++;
        if (axis_out_md_tvalid !== 1'b1 || axis_out_md_tdata !== zero_hdr) begin
            failures++;
            $display("FAIL single_md: got v=%b d=%h want v=1 d=%h", axis_out_md_tvalid, axis_out_md_tdata, zero_hdr);
        end
        drive_beat(rnd_data(), '1, 1'b0);
        drive_beat(rnd_data(), 16'h00ff, 1'b1);
        checks++;
        if (axis_out1_tvalid !== 1'b1 || axis_out1_tlast !== 1'b1 || axis_out2_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_last: got o1v=%b o1l=%b o2v=%b want 1/1/0", axis_out1_tvalid, axis_out1_tlast, axis_out2_tvalid);
        end
        idle(2);
        checks++;
        if (pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL single_count: got %0d want 1", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        data_t hdr, held;
        int    w;
        all_ready();
        axis_out2_tready = 1'b0;
        md_enable = 1'b1;
        hdr    = rnd_data();
        hdr[0] = 1'b1;
        fork
            begin
                drive_beat(hdr, '1, 1'b0);
                for (int i = 0; i < 3; i++) drive_beat(rnd_data(), keep_t'($urandom()), i == 2);
                axis_in_tvalid = 1'b0;
            end
            begin
                w = 0;
                @(negedge clk);
                while (axis_out2_tvalid !== 1'b1 && w < 20) begin
                    w++;
                    @(negedge clk);
                end
                held = axis_out2_tdata;
                repeat (4) begin
                    checks++;
                    if (axis_in_tready !== 1'b0 || axis_out2_tvalid !== 1'b1 || axis_out2_tdata !== held) begin
                        failures++;
                        $display("FAIL bp_stall: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", axis_in_tready,
                                 axis_out2_tvalid, axis_out2_tdata, held);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                axis_out2_tready = 1'b1;
            end
        join
        idle(3);
        checks++;
        if (pkt_count !== 16'd2) begin
            failures++;
            $display("FAIL bp_count: got %0d want 2", pkt_count);
        end
    endtask

    task automatic test_back_to_back();
        int start, span;
        logic [15:0] c0;
        all_ready();
        md_enable = 1'b0;
        c0    = pkt_count;
        start = cyc;
        drive_beat(rnd_data(), 16'h0001, 1'b0);
        drive_beat(rnd_data(), 16'h00f0, 1'b1);
        drive_beat(rnd_data(), 16'h0f00, 1'b0);
        drive_beat(rnd_data(), 16'hf000, 1'b1);
        span = cyc - start;
        idle(2);
        checks++;
        if (span != 4) begin
            failures++;
            $display("FAIL b2b_throughput: got %0d cycles want 4", span);
        end
        checks++;
        if (pkt_count !== c0 + 16'd2) begin
            failures++;
            $display("FAIL b2b_count: got %0d want %0d", pkt_count, c0 + 16'd2);
        end
    endtask

    task automatic test_hdr_only();
        data_t       hdr;
        logic [15:0] c0;
        all_ready();
        md_enable = 1'b1;
        c0 = pkt_count;
        checks++;
        if (hdr_only_err !== 1'b0) begin
            failures++;
            $display("FAIL hdr_err_pre: got %b want 0", hdr_only_err);
        end
        hdr = rnd_data();
        drive_beat(hdr, '1, 1'b1);
        checks++;
        if (hdr_only_err !== 1'b1 || pkt_count !== c0 + 16'd1 || axis_out_md_tdata !== hdr) begin
            failures++;
            $display("FAIL hdr_only: got err=%b cnt=%0d md=%h want 1/%0d/%h", hdr_only_err, pkt_count,
                     axis_out_md_tdata, c0 + 16'd1, hdr);
        end
        hdr = rnd_data();
        drive_beat(hdr, '1, 1'b0);
        checks++;
        if (axis_out_md_tvalid !== 1'b1 || axis_out_md_tdata !== hdr) begin
            failures++;
            $display("FAIL hdr_next: got v=%b d=%h want v=1 d=%h", axis_out_md_tvalid, axis_out_md_tdata, hdr);
        end
        drive_beat(rnd_data(), '1, 1'b1);
        idle(2);
    endtask

    task automatic test_random();
        bit md_en;
        rand_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            md_en = 1'($urandom());
            send_pkt(md_en, 1'($urandom()), md_en ? $urandom_range(0, 4) : $urandom_range(1, 4), 1'b1);
        end
        idle(10);
        all_ready();
        idle(3);
    endtask

    task automatic test_reset_mid_pkt();
        data_t hdr;
        all_ready();
        md_enable = 1'b1;
        hdr    = rnd_data();
        hdr[0] = 1'b1;
        drive_beat(hdr, '1, 1'b0);
        drive_beat(rnd_data(), '1, 1'b0);
        md_enable = 1'b0;
        drive_beat(rnd_data(), 16'h3c3c, 1'b0);
        axis_in_tvalid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({axis_out_md_tvalid, axis_out1_tvalid, axis_out2_tvalid} !== 3'b000 ||
            pkt_count !== 16'd0 || hdr_only_err !== 1'b0 || axis_in_tready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got v=%b cnt=%0d err=%b rdy=%b want 000/0/0/0",
                     {axis_out_md_tvalid, axis_out1_tvalid, axis_out2_tvalid}, pkt_count, hdr_only_err, axis_in_tready);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        md_enable = 1'b1;
        hdr = rnd_data();
        drive_beat(hdr, '1, 1'b0);
        checks++;
        if (axis_out_md_tvalid !== 1'b1 || axis_out_md_tdata !== hdr) begin
            failures++;
            $display("FAIL post_reset_hdr: got v=%b d=%h want v=1 d=%h", axis_out_md_tvalid, axis_out_md_tdata, hdr);
        end
        drive_beat(rnd_data(), '1, 1'b1);
        idle(2);
    endtask

    task automatic test_wrap();
        do_reset();
        all_ready();
        md_enable = 1'b0;
        for (int i = 0; i < 65535; i++) drive_beat(rnd_data(), keep_t'($urandom()), 1'b1);
        idle(2);
        checks++;
        if (pkt_count !== 16'hffff) begin
            failures++;
            $display("FAIL wrap_max: got %h want ffff", pkt_count);
        end
        drive_beat(rnd_data(), '1, 1'b1);
        idle(2);
        checks++;
        if (pkt_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero: got %h want 0000", pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_md();
        test_backpressure();
        test_back_to_back();
        test_hdr_only();
        test_random();
        test_reset_mid_pkt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
